// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared definitions for the iterative multiply/divide sequencer:
//   - op_e       : MULT / MULTU / DIV / DIVU encodings of the 2-bit op field
//   - state_e    : sequencer FSM states (IDLE, CALC, FIX)
//   - alu_ctrl_e : the CPU's 4-bit ALU control codes; the step datapath only
//                  uses ADD and SUB to pick between shift-add and shift-subtract
//   - small helpers that classify an op
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001
    } alu_ctrl_e;

    // Signed ops are the ones with op[0] clear (MULT, DIV).
    function automatic logic is_signed_op(input op_e op);
        return ~op[0];
    endfunction

    // Divide ops are the ones with op[1] set (DIV, DIVU).
    function automatic logic is_div_op(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single-iteration datapath shared by multiply and divide.
// The working register acc holds {upper half, lower half}:
//   multiply (ALU_ADD): acc = {partial product, remaining multiplier bits};
//                       add m to the upper half when acc[0]=1, then shift the
//                       whole 65-bit {carry, acc} right by one.
//   divide   (ALU_SUB): acc = {partial remainder, remaining dividend/quotient};
//                       shift left by one, trial-subtract m from the upper part,
//                       keep the difference when it is non-negative (restoring),
//                       and shift the quotient bit into acc[0].
// Ports:
//   alu_ctrl  in   selects add (multiply) or subtract (divide)
//   acc_in    in   2*WIDTH working register before the step
//   m         in   WIDTH multiplicand magnitude / divisor magnitude
//   acc_out   out  2*WIDTH working register after the step
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_ctrl_e            alu_ctrl,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     m,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic             is_sub;
    logic             q_bit;
    logic [WIDTH:0]   x;
    logic [WIDTH:0]   y;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   kept;

    always_comb begin
        is_sub = (alu_ctrl == ALU_SUB);
        // Divide looks at the remainder already shifted left by one with the
        // next dividend bit appended; multiply looks at the plain upper half.
        x      = is_sub ? acc_in[2*WIDTH-1:WIDTH-1] : {1'b0, acc_in[2*WIDTH-1:WIDTH]};
        // One adder: subtraction is x + ~y + 1.
        y      = {1'b0, m} ^ {(WIDTH+1){is_sub}};
        sum    = x + y + {{WIDTH{1'b0}}, is_sub};
        // The partial remainder is always below m, so the difference fits in
        // WIDTH+1 signed bits and its top bit is the borrow.
        q_bit  = ~sum[WIDTH];
        if (is_sub) begin
            kept    = q_bit ? sum : x;
            acc_out = {kept[WIDTH-1:0], acc_in[WIDTH-2:0], q_bit};
        end else begin
            kept    = acc_in[0] ? sum : x;
            acc_out = {kept, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage with architectural HI/LO.
// Operands are reduced to magnitudes on accept, processed for STEPS cycles by
// muldiv_step, sign-corrected in one FIX cycle, then committed to HI/LO.
// Ports:
//   clk, rst_n        clock (rising edge) / synchronous active-low reset
//   start, op, a, b   issue request, accepted only in IDLE (op: see op_e)
//   cancel            pipeline flush; aborts an in-flight operation
//   we_hi, we_lo      MTHI / MTLO strobes, honoured only in IDLE
//   wdata             MTHI / MTLO data
//   busy              operation in flight (CALC or FIX)
//   done              one-cycle pulse after HI/LO were committed
//   hi, lo            HI / LO registers
// STEPS must equal WIDTH.
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cancel,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [WIDTH-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CNT_W = $clog2(STEPS);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    op_e                  op_q, op_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    alu_ctrl_e            alu_ctrl;
    logic [2*WIDTH-1:0]   step_acc;
    op_e                  op_in;
    logic                 in_neg_a, in_neg_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     quot, rem;
    logic [2*WIDTH-1:0]   prod;

    assign alu_ctrl = is_div_op(op_q) ? ALU_SUB : ALU_ADD;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .alu_ctrl (alu_ctrl),
        .acc_in   (acc_q),
        .m        (m_q),
        .acc_out  (step_acc)
    );

    always_comb begin
        // NOTE: every *_d and temporary gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        div0_d   = div0_q;
        m_d      = m_q;
        dvd_d    = dvd_q;
        acc_d    = acc_q;

        op_in    = op_e'(op);
        in_neg_a = is_signed_op(op_in) && a[WIDTH-1];
        in_neg_b = is_signed_op(op_in) && b[WIDTH-1];
        // Magnitudes are unsigned WIDTH-bit values, so -0x80000000 stays 0x80000000.
        mag_a    = in_neg_a ? -a : a;
        mag_b    = in_neg_b ? -b : b;

        quot     = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        prod     = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;

        unique case (state_q)
            IDLE: begin
                if (we_hi) hi_d = wdata;
                if (we_lo) lo_d = wdata;
                if (start && !cancel) begin
                    op_d    = op_in;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    div0_d  = is_div_op(op_in) && (b == '0);
                    // Same layout for both: |a| in the low half, |b| as m.
                    acc_d   = {{WIDTH{1'b0}}, mag_a};
                    m_d     = mag_b;
                    dvd_d   = a;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = step_acc;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(STEPS - 1)) state_d = FIX;
                if (cancel) state_d = IDLE;
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (div0_q) begin
                        hi_d = dvd_q;
                        lo_d = '1;
                    end else if (is_div_op(op_q)) begin
                        hi_d = rem;
                        lo_d = quot;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // NOTE: operand/working registers have no reset; they are always loaded on accept before anything reads them.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        neg_a_q <= neg_a_d;
        neg_b_q <= neg_b_d;
        div0_q  <= div0_d;
        m_q     <= m_d;
        dvd_q   <= dvd_d;
        acc_q   <= acc_d;
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed vectors with hand-computed HI/LO results. Each accepted operation
// pushes its expected {hi, lo} into a queue; a monitor pops and compares on
// every done pulse. Latency, busy length, cancel, reset and ignored-request
// behaviour are checked inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_sequencer #(.WIDTH(32), .STEPS(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .we_hi  (we_hi),
        .we_lo  (we_lo),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic expect_result(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.name = name;
        e.val  = {ehi, elo};
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check(e.name, {hi, lo}, e.val);
            end
        end
    end

    // Called 1ns after a rising edge; the start is sampled at the next edge (E0).
    task automatic start_op(input op_e o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Samples once per cycle until done; lat is the index of the done cycle
    // counted from the first cycle after the call, busy_n the busy cycles before it.
    task automatic wait_done(input string name, output int lat, output int busy_n);
        bit seen = 1'b0;
        lat    = -1;
        busy_n = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = i;
                check({name, "_busy_at_done"}, 64'(busy), 64'd0);
            end else if (busy) begin
                busy_n++;
            end
            @(posedge clk);
            #1;
        end
        check({name, "_completed"}, 64'(seen), 64'd1);
    endtask

    task automatic run_op(input string name, input op_e o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        int busy_n;
        expect_result(name, ehi, elo);
        start_op(o, x, y);
        wait_done(name, lat, busy_n);
        check({name, "_latency"}, 64'(lat), 64'd33);
        check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
    endtask

    initial begin
        int lat;
        int busy_n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Arithmetic vectors
        run_op("multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg3x5",  OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("div_neg7_2",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_neg2",   OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        run_op("divu_by_zero", OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
        run_op("div_by_zero",  OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF);
        run_op("div_min_neg1", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        run_op("divu_min_3",   OP_DIVU,  32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA);
        run_op("mult_min_min", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        // MTHI/MTLO preload in IDLE
        we_hi = 1'b1;
        we_lo = 1'b1;
        wdata = 32'h12345678;
        @(posedge clk);
        #1;
        we_hi = 1'b0;
        we_lo = 1'b0;
        @(negedge clk);
        check("preload_hilo", {hi, lo}, {32'h12345678, 32'h12345678});
        @(posedge clk);
        #1;

        // MULT 7*9 cancelled at E0+10; no result may appear.
        start_op(OP_MULT, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;

        // DIVU 50/7 issued so that it is sampled at E0+11.
        expect_result("divu_50_7", 32'd1, 32'd7);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd50;
        b     = 32'd7;
        @(negedge clk);
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_hilo", {hi, lo}, {32'h12345678, 32'h12345678});
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("restart_accepted", 64'(busy), 64'd1);
        @(posedge clk);
        #1;

        // Second start plus MTLO at E0'+5: both must be ignored.
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd3;
        b     = 32'd3;
        we_lo = 1'b1;
        wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        we_lo = 1'b0;
        @(negedge clk);
        check("we_lo_while_busy", 64'(lo), 64'h12345678);
        @(posedge clk);
        #1;
        wait_done("divu_50_7", lat, busy_n);
        @(negedge clk);
        check("no_queued_start", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Synchronous reset at E0+20 of a following operation.
        start_op(OP_MULTU, 32'h00001234, 32'h00005678);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midop_reset_busy", 64'(busy), 64'd0);
        check("midop_reset_hilo", {hi, lo}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        @(negedge clk);
        check("post_reset_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Recovery after reset
        run_op("multu_2p32",   OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0);

        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
